// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture sequencer.
// Holds the sequencer state encoding, default stream geometry and the
// width of a per-buffer channel index.
package adc_capture_pkg;

    localparam int NCHAN_DEF  = 8;    // ADC stream count
    localparam int NBUF_DEF   = 4;    // buffer stream count
    localparam int DWIDTH_DEF = 128;  // tdata width
    localparam int LENW_DEF   = 16;   // capture-length width
    localparam int CHAN_IDX_W = 3;    // bits per buffer channel selector

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SYNC,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

endpackage

// File: rtl/capture_out_stage.sv
// One buffer output lane: channel select mux, single-word AXI-Stream output
// register and sticky overflow flag.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   adc_tdata       all ADC data lanes
//   sel_i           ADC channel feeding this lane
//   beat_i, last_i  capture beat strobe and final-beat marker
//   clr_ovf_i       clears the overflow flag (new capture armed)
//   tready_i        downstream ready
//   tdata_o, tvalid_o, tlast_o, overflow_o   lane outputs
module capture_out_stage
    import adc_capture_pkg::*;
#(
    parameter int NCHAN  = NCHAN_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NCHAN*DWIDTH-1:0] adc_tdata,
    input  logic [CHAN_IDX_W-1:0]   sel_i,
    input  logic                    beat_i,
    input  logic                    last_i,
    input  logic                    clr_ovf_i,
    input  logic                    tready_i,
    output logic [DWIDTH-1:0]       tdata_o,
    output logic                    tvalid_o,
    output logic                    tlast_o,
    output logic                    overflow_o
);

    logic [DWIDTH-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              ovf_q;
    logic              slot_free;

    // The register may take a new word when empty or when its current word
    // is being accepted in this very cycle.
    assign slot_free = !tvalid_q || tready_i;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (beat_i && slot_free) begin
                tvalid_q <= 1'b1;
                tlast_q  <= last_i;
            end else if (tready_i) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            // A beat landing on a held word is dropped, leaving the held
            // word untouched; only the flag records the loss.
            if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end else if (beat_i && !slot_free) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Data path carries no reset; tvalid qualifies it.
    always_ff @(posedge aclk) begin
        if (beat_i && slot_free) begin
            tdata_q <= adc_tdata[sel_i*DWIDTH +: DWIDTH];
        end
    end

    assign tdata_o    = tdata_q;
    assign tvalid_o   = tvalid_q;
    assign tlast_o    = tlast_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: arm / trigger / optional SYSREF alignment, then
// copies cap_len+1 beats from selected ADC streams into NBUF output streams.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   arm_i, abort_i           single-cycle control requests
//   trig_i, sysref_i         level inputs, rising edges detected internally
//   align_en_i               wait for SYSREF edge after trigger
//   cap_len_i, chan_sel_i    capture length minus one, per-buffer channel
//   adc_tdata, adc_tvalid    ADC streams (always accepted)
//   buf_tdata/tvalid/tlast/tready   buffer output streams
//   busy_o, done_o, overflow_o      status
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int NCHAN  = NCHAN_DEF,
    parameter int NBUF   = NBUF_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LENW   = LENW_DEF
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       arm_i,
    input  logic                       abort_i,
    input  logic                       trig_i,
    input  logic                       sysref_i,
    input  logic                       align_en_i,
    input  logic [LENW-1:0]            cap_len_i,
    input  logic [NBUF*CHAN_IDX_W-1:0] chan_sel_i,
    input  logic [NCHAN*DWIDTH-1:0]    adc_tdata,
    input  logic [NCHAN-1:0]           adc_tvalid,
    output logic [NBUF*DWIDTH-1:0]     buf_tdata,
    output logic [NBUF-1:0]            buf_tvalid,
    output logic [NBUF-1:0]            buf_tlast,
    input  logic [NBUF-1:0]            buf_tready,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NBUF-1:0]            overflow_o
);

    cap_state_e                 state_q;
    logic [LENW-1:0]            cnt_q;
    logic [LENW-1:0]            cap_len_q;
    logic [NBUF*CHAN_IDX_W-1:0] chan_sel_q;
    logic                       align_q;
    logic                       trig_prev_q;
    logic                       sysref_prev_q;
    logic                       busy_q;
    logic                       done_q;

    logic trig_edge;
    logic sysref_edge;
    logic all_valid;
    logic beat;
    logic last_beat;
    logic arm_fire;

    assign trig_edge   = trig_i & ~trig_prev_q;
    assign sysref_edge = sysref_i & ~sysref_prev_q;

    // A beat needs every selected stream valid at once so all buffers stay
    // beat-aligned.
    always_comb begin
        all_valid = 1'b1;
        for (int k = 0; k < NBUF; k++) begin
            if (!adc_tvalid[chan_sel_q[k*CHAN_IDX_W +: CHAN_IDX_W]]) begin
                all_valid = 1'b0;
            end
        end
    end

    assign beat      = (state_q == ST_CAPTURE) && !abort_i && all_valid;
    assign last_beat = beat && (cnt_q == cap_len_q);
    assign arm_fire  = (state_q == ST_IDLE) && arm_i && !abort_i;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cap_len_q     <= '0;
            chan_sel_q    <= '0;
            align_q       <= 1'b0;
            trig_prev_q   <= 1'b0;
            sysref_prev_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            trig_prev_q   <= trig_i;
            sysref_prev_q <= sysref_i;
            done_q        <= 1'b0;
            if (abort_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm_i) begin
                            state_q    <= ST_ARMED;
                            busy_q     <= 1'b1;
                            cap_len_q  <= cap_len_i;
                            chan_sel_q <= chan_sel_i;
                            align_q    <= align_en_i;
                            cnt_q      <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_edge) begin
                            state_q <= align_q ? ST_SYNC : ST_CAPTURE;
                        end
                    end
                    ST_SYNC: begin
                        if (sysref_edge) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (last_beat) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (beat) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_out
            capture_out_stage #(
                .NCHAN  (NCHAN),
                .DWIDTH (DWIDTH)
            ) u_stage (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .adc_tdata  (adc_tdata),
                .sel_i      (chan_sel_q[gi*CHAN_IDX_W +: CHAN_IDX_W]),
                .beat_i     (beat),
                .last_i     (last_beat),
                .clr_ovf_i  (arm_fire),
                .tready_i   (buf_tready[gi]),
                .tdata_o    (buf_tdata[gi*DWIDTH +: DWIDTH]),
                .tvalid_o   (buf_tvalid[gi]),
                .tlast_o    (buf_tlast[gi]),
                .overflow_o (overflow_o[gi])
            );
        end
    endgenerate

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameters: NCHAN, 8, ADC stream count; NBUF, 4, buffer stream count; DWIDTH, 128, tdata width; LENW, 16, capture-length width.
REQ-002 aclk  in  1  sole clock, all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 arm_i  in  1  single-cycle arm request.
REQ-005 abort_i  in  1  single-cycle abort request.
REQ-006 trig_i  in  1  capture trigger, level, rising-edge detected internally.
REQ-007 sysref_i  in  1  SYSREF already registered in aclk, rising-edge detected internally.
REQ-008 align_en_i  in  1  1 = start capture on first SYSREF edge after trigger.
REQ-009 cap_len_i  in  LENW  capture length minus one, in beats.
REQ-010 chan_sel_i  in  NBUF*3  per-buffer ADC channel index, buffer k in bits [3k+2:3k].
REQ-011 adc_tdata  in  NCHAN*DWIDTH / adc_tvalid  in  NCHAN  ADC streams, no tready (always accepted).
REQ-012 buf_tdata  out  NBUF*DWIDTH / buf_tvalid  out  NBUF / buf_tlast  out  NBUF / buf_tready  in  NBUF  buffer streams.
REQ-013 busy_o  out  1  high in any state except IDLE; done_o  out  1  one-cycle completion pulse; overflow_o  out  NBUF  sticky per-buffer drop flag.

Function
REQ-014 States IDLE, ARMED, SYNC, CAPTURE, DONE.
REQ-015 IDLE->ARMED on arm_i; cap_len_i and chan_sel_i latched that cycle; beat counter and overflow_o cleared.
REQ-016 arm_i outside IDLE ignored; trig_i edge in the arm cycle is ignored.
REQ-017 ARMED->CAPTURE on trig_i rising edge when latched align_en_i=0; ARMED->SYNC when align_en_i=1 (align_en_i latched at arm).
REQ-018 SYNC->CAPTURE on sysref_i rising edge; edge coincident with the SYNC-entry cycle is not used.
REQ-019 Beat = CAPTURE cycle with adc_tvalid high on every latched selected channel; non-beat cycles forward nothing.
REQ-020 Each beat loads buffer k's output register with adc_tdata of its selected channel; buf_tvalid rises 1 cycle after the beat.
REQ-021 Beat counter increments per beat; beat with count == latched cap_len sets buf_tlast on all buffers, CAPTURE->DONE; total beats = cap_len+1 (max 65536, no wrap).
REQ-022 DONE: done_o high one cycle, ->IDLE next cycle.
REQ-023 AXI rule: buf_tvalid/tdata/tlast held stable until buf_tready; register freed on tready and reloadable same cycle.
REQ-024 Beat arriving while buffer k holds an unaccepted word: new word dropped, overflow_o[k] set, counter still advances; tlast of a dropped final beat is lost.
REQ-025 abort_i in any state -> IDLE next cycle, no done_o; pending output words stay valid until accepted; abort wins over simultaneous arm_i.
REQ-026 Two buffers may select the same channel; both receive identical data.

Reset
REQ-027 aresetn low on a rising edge: state IDLE, counter 0, edge-detect history 0, buf_tvalid/buf_tlast 0, busy_o/done_o 0, overflow_o 0; buf_tdata reset-free.
REQ-028 Reset mid-capture discards pending output words (AXI exception accepted at reset).

Structure
REQ-029 Shared package adc_capture_pkg holds state enum, NCHAN/NBUF/DWIDTH/LENW defaults, channel-index width.
REQ-030 One sub-module capture_out_stage (per-buffer select mux, output register, overflow flag) instantiated NBUF times in a generate loop.

Verification
REQ-031 cap_len=3, align=0, chan_sel={7,5,2,0}, all tready=1, ramp data: arm, trig -> 4 beats per buffer matching channels, tlast on 4th, done_o one cycle after last beat.
REQ-032 align=1, sysref edge 10 cycles after trig -> first buf_tvalid 2 cycles after the sysref edge (edge-detect + output register), none before.
REQ-033 cap_len=7, buf_tready[1] low cycles 2-4 of capture -> buffer 1 holds word 1 stable, overflow_o[1]=1, other buffers unaffected, 8 beats counted.
REQ-034 abort_i 3 beats into cap_len=99 -> busy_o low next cycle, no done_o, no tlast, pending words drain.
REQ-035 arm_i and abort_i same cycle; arm_i during CAPTURE; trig_i in arm cycle -> state stays IDLE / unchanged / ARMED respectively.
REQ-036 aresetn low mid-capture -> all outputs at reset values next cycle; new arm/trig capture completes normally.
